// File: rtl/mem_port_responder.sv
// Data-memory responder: accepts one load/store at a time, inserts WAIT_CYC wait states, answers over valid/ready.
// Optional MEM_BOUNDS_CHECK_EN: out-of-range addresses skip the RAM, return zero data and raise resp_err.
module mem_port_responder #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 16,
  parameter int DEPTH    = 1024,
  parameter int WAIT_CYC = 1
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              busy
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [3:0] CNT_LOAD = (WAIT_CYC > 0) ? 4'(WAIT_CYC - 1) : 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACCESS,
    ST_RESP
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              valid_q, valid_d;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] rd_word;
  logic              in_range;
  logic              mem_we;

  assign idx     = addr_q[IDX_W-1:0];
  assign rd_word = mem[idx];

`ifdef MEM_BOUNDS_CHECK_EN
  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  logic err_q, err_d;

  assign in_range = ({1'b0, addr_q} < DEPTH_EXT);
  assign resp_err = err_q;
`else
  // Upper address bits are captured but intentionally dropped: addresses alias modulo DEPTH.
  logic unused_addr_bits;

  assign unused_addr_bits = ^addr_q;
  assign in_range = 1'b1;
  assign resp_err = 1'b0;
`endif

  assign req_ready  = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign resp_valid = valid_q;
  assign resp_rdata = rdata_q;
  assign mem_we     = (state_q == ST_ACCESS) && we_q && in_range;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    valid_d = valid_q;
`ifdef MEM_BOUNDS_CHECK_EN
    err_d   = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
`ifdef MEM_BOUNDS_CHECK_EN
          err_d   = 1'b0;
`endif
          if (WAIT_CYC == 0) begin
            state_d = ST_ACCESS;
          end else begin
            cnt_d   = CNT_LOAD;
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_ACCESS;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_ACCESS: begin
        rdata_d = we_q ? wdata_q : rd_word;
`ifdef MEM_BOUNDS_CHECK_EN
        if (!in_range) begin
          rdata_d = '0;
          err_d   = 1'b1;
        end
`endif
        valid_d = 1'b1;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (resp_ready) begin
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      valid_q <= 1'b0;
`ifdef MEM_BOUNDS_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      valid_q <= valid_d;
`ifdef MEM_BOUNDS_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

  // RAM is never reset; a reset before the ACCESS edge leaves state_q in IDLE, so nothing commits.
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      mem[idx] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_mem_port_responder.sv
// Scoreboard bench for mem_port_responder: randomized loads/stores checked against a word-array model.
// A second zero-wait instance covers the WAIT_CYC=0 latency and busy window.
`timescale 1ns/1ps
module tb_mem_port_responder;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 16;
  localparam int DEPTH    = 1024;
  localparam int WAIT_CYC = 3;

  logic              CLK = 1'b0;
  logic              reset = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [DATA_W-1:0] req_wdata = '0;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;
  logic              busy;

  logic              z_req_valid = 1'b0;
  logic              z_req_ready;
  logic              z_req_we = 1'b0;
  logic [ADDR_W-1:0] z_req_addr = '0;
  logic [DATA_W-1:0] z_req_wdata = '0;
  logic              z_resp_valid;
  logic              z_resp_ready = 1'b1;
  logic [DATA_W-1:0] z_resp_rdata;
  logic              z_resp_err;
  logic              z_busy;

  mem_port_responder #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .WAIT_CYC(WAIT_CYC)
  ) u_dut (
    .CLK(CLK), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .busy(busy)
  );

  mem_port_responder #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .WAIT_CYC(0)
  ) u_dut_z (
    .CLK(CLK), .reset(reset),
    .req_valid(z_req_valid), .req_ready(z_req_ready), .req_we(z_req_we),
    .req_addr(z_req_addr), .req_wdata(z_req_wdata),
    .resp_valid(z_resp_valid), .resp_ready(z_resp_ready),
    .resp_rdata(z_resp_rdata), .resp_err(z_resp_err), .busy(z_busy)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int rr_mode = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic [DATA_W-1:0] rdata;
    logic              err;
    int                acc;
  } exp_t;

  exp_t              exp_q[$];
  exp_t              head;
  logic [DATA_W-1:0] model_mem [DEPTH];
  bit                in_resp = 1'b0;
  bit                chk_idle = 1'b0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: RAM is a plain array; an address either aliases modulo DEPTH or is rejected.
  function automatic exp_t model_access(input logic we, input logic [ADDR_W-1:0] addr,
                                        input logic [DATA_W-1:0] wdata);
    exp_t e;
    int   idx;
    idx   = int'(addr) % DEPTH;
    e.err = 1'b0;
    e.acc = 0;
`ifdef MEM_BOUNDS_CHECK_EN
    if (int'(addr) >= DEPTH) begin
      e.rdata = '0;
      e.err   = 1'b1;
      return e;
    end
`endif
    if (we) begin
      model_mem[idx] = wdata;
      e.rdata        = wdata;
    end else begin
      e.rdata = model_mem[idx];
    end
    return e;
  endfunction

  initial begin
    resp_ready = 1'b0;
    forever begin
      @(posedge CLK);
      #1;
      case (rr_mode)
        0:       resp_ready = ($urandom_range(0, 3) != 0);
        1:       resp_ready = 1'b1;
        default: resp_ready = 1'b0;
      endcase
    end
  end

  // Monitor: compares every cycle a response is presented, pops on the handshake.
  always @(negedge CLK) begin
    if (reset === 1'b1) begin
      if (resp_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL resp_unexpected: got resp_valid=1 rdata=0x%0h, expected no response", resp_rdata);
        end else begin
          head = exp_q[0];
          if (!in_resp) begin
            check_output("resp_latency", cyc - head.acc, WAIT_CYC + 1);
            in_resp = 1'b1;
          end
          check_output("resp_rdata", resp_rdata, head.rdata);
          check_output("resp_err", resp_err, head.err);
          check_output("req_ready_in_resp", req_ready, 0);
          if (resp_ready) begin
            exp_q.delete(0);
            in_resp  = 1'b0;
            chk_idle = 1'b1;
          end
        end
      end else begin
        if (chk_idle) begin
          check_output("idle_after_resp{busy,req_ready}", {busy, req_ready}, 2'b01);
          chk_idle = 1'b0;
        end
        in_resp = 1'b0;
      end
    end else begin
      in_resp  = 1'b0;
      chk_idle = 1'b0;
    end
  end

  task automatic apply_stimulus(input logic we, input logic [ADDR_W-1:0] addr,
                                input logic [DATA_W-1:0] wdata, input bit track);
    exp_t e;
    int   n;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_valid = 1'b1;
    n = 0;
    @(negedge CLK);
    while (!req_ready && n < 64) begin
      @(negedge CLK);
      n++;
    end
    if (!req_ready) begin
      checks++;
      failures++;
      $display("[TB] FAIL accept_timeout: got req_ready=0 for 64 cycles, expected 1");
      req_valid = 1'b0;
      return;
    end
    if (track) begin
      e     = model_access(we, addr, wdata);
      e.acc = cyc + 1;
      exp_q.push_back(e);
    end
    @(posedge CLK);
    #1;
    req_valid = 1'b0;
    req_we    = 1'($urandom);
    req_addr  = ADDR_W'($urandom);
    req_wdata = DATA_W'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge CLK);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL drain_timeout: got %0d responses outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic z_xfer(input logic we, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata,
                        output logic [DATA_W-1:0] rdata, output int lat, output int bsy);
    z_req_we    = we;
    z_req_addr  = addr;
    z_req_wdata = wdata;
    z_req_valid = 1'b1;
    @(negedge CLK);
    check_output("z_req_ready_idle", z_req_ready, 1);
    @(posedge CLK);
    #1;
    z_req_valid = 1'b0;
    z_req_addr  = ADDR_W'($urandom);
    lat   = -1;
    bsy   = 0;
    rdata = '0;
    for (int k = 0; k < 20; k++) begin
      @(negedge CLK);
      if (z_busy) bsy++;
      if (z_resp_valid && lat < 0) begin
        lat   = k;
        rdata = z_resp_rdata;
        check_output("z_resp_err", z_resp_err, 0);
      end
      if (!z_busy && lat >= 0) break;
    end
    @(posedge CLK);
    #1;
  endtask

  initial begin
    logic [DATA_W-1:0] rd;
    int lat, bsy, n, idx;
    logic [ADDR_W-1:0] a;

    #12;
    check_output("reset_outputs{valid,rdata,err,busy}", {resp_valid, resp_rdata, resp_err, busy}, 0);
    @(posedge CLK);
    #3;
    reset = 1'b1;
    @(negedge CLK);
    check_output("post_reset_req_ready", req_ready, 1);
    @(posedge CLK);
    #1;

    for (int i = 0; i < 64; i++) begin
      apply_stimulus(1'b1, ADDR_W'(i), DATA_W'($urandom), 1'b1);
    end
    apply_stimulus(1'b1, 16'h0010, 16'hBEEF, 1'b1);
    apply_stimulus(1'b0, 16'h0010, 16'h0000, 1'b1);
    drain();

    // Busy window with resp_ready held high: WAIT_CYC waits + ACCESS + RESP.
    rr_mode = 1;
    @(posedge CLK);
    #1;
    apply_stimulus(1'b0, 16'h0003, 16'h0000, 1'b1);
    bsy = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge CLK);
      if (busy) bsy++;
      else break;
    end
    check_output("busy_cycles", bsy, WAIT_CYC + 2);
    drain();

    rr_mode = 2;
    @(posedge CLK);
    #1;
    apply_stimulus(1'b0, 16'h0007, 16'h0000, 1'b1);
    n = 0;
    while (!resp_valid && n < 20) begin
      @(negedge CLK);
      n++;
    end
    repeat (5) @(negedge CLK);
    check_output("backpressure_valid_held", resp_valid, 1);
    rr_mode = 1;
    drain();

    rr_mode = 0;
    apply_stimulus(1'b0, 16'h0011, 16'h0000, 1'b1);
    req_we    = 1'b1;
    req_addr  = 16'h0020;
    req_wdata = 16'h1234;
    req_valid = 1'b1;
    @(negedge CLK);
    check_output("req_ready_while_busy", req_ready, 0);
    @(posedge CLK);
    #1;
    req_valid = 1'b0;
    drain();
    apply_stimulus(1'b0, 16'h0020, 16'h0000, 1'b1);
    drain();

    apply_stimulus(1'b1, 16'h0030, 16'h5555, 1'b1);
    drain();
    apply_stimulus(1'b1, 16'h0030, 16'hAAAA, 1'b0);
    @(posedge CLK);
    #3;
    reset = 1'b0;
    #1;
    check_output("midop_reset_outputs{valid,rdata,err,busy}", {resp_valid, resp_rdata, resp_err, busy}, 0);
    @(posedge CLK);
    #3;
    reset = 1'b1;
    @(negedge CLK);
    check_output("midop_release_req_ready", req_ready, 1);
    @(posedge CLK);
    #1;
    apply_stimulus(1'b0, 16'h0030, 16'h0000, 1'b1);
    drain();

    apply_stimulus(1'b1, 16'h0405, 16'h7777, 1'b1);
    apply_stimulus(1'b0, 16'h0405, 16'h0000, 1'b1);
    apply_stimulus(1'b0, 16'h0005, 16'h0000, 1'b1);
    drain();

    for (int t = 0; t < 150; t++) begin
      idx = int'($urandom_range(0, 63));
      case ($urandom_range(0, 7))
        6:       a = ADDR_W'(idx + DEPTH * int'($urandom_range(1, 63)));
        7:       a = ADDR_W'(idx + DEPTH * 63);
        default: a = ADDR_W'(idx);
      endcase
      apply_stimulus(1'($urandom), a, DATA_W'($urandom), 1'b1);
      repeat ($urandom_range(0, 2)) @(posedge CLK);
      #1;
    end
    drain();

    z_xfer(1'b1, 16'h0010, 16'hBEEF, rd, lat, bsy);
    check_output("z_store_rdata", rd, 16'hBEEF);
    check_output("z_store_latency", lat, 1);
    check_output("z_store_busy_cycles", bsy, 2);
    z_xfer(1'b0, 16'h0010, 16'h0000, rd, lat, bsy);
    check_output("z_load_rdata", rd, 16'hBEEF);
    check_output("z_load_latency", lat, 1);
    check_output("z_load_busy_cycles", bsy, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no completion by 500us, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
